// File: rtl/stream_splitter_pkg.sv
// stream_splitter_pkg: shared state type and sizing helpers for the stream
// splitter (word-to-chunk serializer).
package stream_splitter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Number of chunks a word splits into.
  function automatic int chunk_count(input int w_in, input int w_out);
    return w_in / w_out;
  endfunction

  // Width of the chunk index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_splitter_if.sv
// stream_splitter_if: word-in / chunk-out handshake bundle.
// With STREAM_SPLITTER_PARITY_EN defined the bundle carries out_parity.
interface stream_splitter_if
  import stream_splitter_pkg::*;
#(
  parameter int W_IN  = 32,
  parameter int W_OUT = 8
);
  localparam int N     = chunk_count(W_IN, W_OUT);
  localparam int IDX_W = idx_width(N);

  logic             in_valid;
  logic             in_ready;
  logic [W_IN-1:0]  in_data;
  logic             in_msb_first;
  logic             out_valid;
  logic             out_ready;
  logic [W_OUT-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
`ifdef STREAM_SPLITTER_PARITY_EN
  logic             out_parity;

  modport master (
    output in_valid, in_data, in_msb_first, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, out_parity
  );
  modport slave (
    input  in_valid, in_data, in_msb_first, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, out_parity
  );
`else
  modport master (
    output in_valid, in_data, in_msb_first, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );
  modport slave (
    input  in_valid, in_data, in_msb_first, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
`endif

endinterface

// File: rtl/stream_splitter_chunk_sel.sv
// stream_splitter_chunk_sel: picks chunk idx out of a word, counting from the
// top (msb_first = 1) or from the bottom (msb_first = 0). Purely combinational.
module stream_splitter_chunk_sel #(
  parameter int W_IN  = 32,
  parameter int W_OUT = 8,
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [W_IN-1:0]  word,
  input  logic             msb_first,
  input  logic [IDX_W-1:0] idx,
  output logic [W_OUT-1:0] chunk
);

  // Index mux over all N chunk positions; out-of-range idx yields zero.
  always_comb begin
    chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        if (msb_first) chunk = word[W_IN-1-k*W_OUT -: W_OUT];
        else           chunk = word[k*W_OUT +: W_OUT];
      end
    end
  end

endmodule

// File: rtl/stream_splitter.sv
// stream_splitter: accepts one W_IN-bit word and emits it as N = W_IN/W_OUT
// chunks over a valid/ready handshake, with no bubble between words.
// Optional feature macro: STREAM_SPLITTER_PARITY_EN adds a registered
// out_parity (= ^out_data, 0 while idle).
//
// state | meaning
// IDLE  | no word held, in_ready = 1, out_valid = 0
// SEND  | word held, chunk idx_q presented on out_data
module stream_splitter
  import stream_splitter_pkg::*;
#(
  parameter int W_IN  = 32,
  parameter int W_OUT = 8
) (
  input logic              clk,
  input logic              reset_n,
  stream_splitter_if.slave bus
);
  localparam int N     = chunk_count(W_IN, W_OUT);
  localparam int IDX_W = idx_width(N);

  if ((W_IN % W_OUT) != 0 || N < 2) begin : g_bad_params
    $error("stream_splitter: W_IN must be a multiple of W_OUT with at least two chunks");
  end

  state_t           state_q, state_d;
  logic [W_IN-1:0]  word_q, word_d;
  logic             msb_q, msb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W_OUT-1:0] out_data_q, out_data_d;
  logic [W_OUT-1:0] sel_chunk;
  logic             in_ready;
  logic             out_last;
  logic             in_acc;
  logic             out_acc;

  // Chunk for the next cycle is selected from the next-state word/index so
  // that out_data can be a plain register.
  stream_splitter_chunk_sel #(
    .W_IN (W_IN),
    .W_OUT(W_OUT),
    .N    (N),
    .IDX_W(IDX_W)
  ) u_chunk_sel (
    .word     (word_d),
    .msb_first(msb_d),
    .idx      (idx_d),
    .chunk    (sel_chunk)
  );

  assign out_data_d = (state_d == SEND) ? sel_chunk : '0;

  // State and datapath registers; reset discards any held word at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      msb_q      <= 1'b0;
      idx_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      msb_q      <= msb_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
    end
  end

  // Next-state logic and handshake decode; in_ready never depends on in_valid.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    msb_d    = msb_q;
    idx_d    = idx_q;
    out_last = (state_q == SEND) && (idx_q == IDX_W'(N - 1));
    in_ready = (state_q == IDLE) || (out_last && bus.out_ready);
    in_acc   = bus.in_valid && in_ready;
    out_acc  = (state_q == SEND) && bus.out_ready;

    case (state_q)
      IDLE: begin
        if (in_acc) begin
          word_d  = bus.in_data;
          msb_d   = bus.in_msb_first;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_acc) begin
          if (!out_last) begin
            idx_d = idx_q + 1'b1;
          end else if (in_acc) begin
            word_d = bus.in_data;
            msb_d  = bus.in_msb_first;
            idx_d  = '0;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = out_last;

`ifdef STREAM_SPLITTER_PARITY_EN
  logic parity_q;

  // Parity tracks out_data_d so it is zero whenever out_data is zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) parity_q <= 1'b0;
    else          parity_q <= ^out_data_d;
  end

  assign bus.out_parity = parity_q;
`endif

endmodule

// File: tb/tb_stream_splitter.sv
// tb_stream_splitter: directed scenarios plus randomized traffic checked
// against a chunk-queue reference model.
module tb_stream_splitter;
  import stream_splitter_pkg::*;

`ifdef STREAM_SPLITTER_PARITY_EN
  localparam int W_IN  = 16;
  localparam int W_OUT = 4;
`else
  localparam int W_IN  = 32;
  localparam int W_OUT = 8;
`endif
  localparam int N     = chunk_count(W_IN, W_OUT);
  localparam int IDX_W = idx_width(N);

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  stream_splitter_if #(.W_IN(W_IN), .W_OUT(W_OUT)) bus ();

  stream_splitter #(.W_IN(W_IN), .W_OUT(W_OUT)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the chunks still owed to the consumer, in order.
  typedef struct {
    logic [W_OUT-1:0] data;
    int               idx;
  } chunk_t;
  chunk_t q[$];

  function automatic bit exp_in_ready();
    return (q.size() == 0) || (q.size() == 1 && bus.out_ready);
  endfunction

  function automatic void push_word(input logic [W_IN-1:0] w, input logic msb);
    chunk_t c;
    int sh;
    for (int k = 0; k < N; k++) begin
      sh     = msb ? (N - 1 - k) * W_OUT : k * W_OUT;
      c.data = W_OUT'(w >> sh);
      c.idx  = k;
      q.push_back(c);
    end
  endfunction

  task automatic drive(input logic iv, input logic [W_IN-1:0] d,
                       input logic msb, input logic ordy);
    bus.in_valid     = iv;
    bus.in_data      = d;
    bus.in_msb_first = msb;
    bus.out_ready    = ordy;
    #1;
  endtask

  // One clock: update the model from the handshakes it predicts, land on negedge.
  task automatic advance();
    bit ina, outa;
    ina  = bus.in_valid && exp_in_ready();
    outa = (q.size() > 0) && bus.out_ready;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
    end else begin
      if (outa) void'(q.pop_front());
      if (ina) push_word(bus.in_data, bus.in_msb_first);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    q.delete();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_idx !== '0 ||
        bus.out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b data=%h idx=%0d last=%b, want all 0",
               bus.out_valid, bus.out_data, bus.out_idx, bus.out_last);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
`ifdef STREAM_SPLITTER_PARITY_EN
    n_checks++;
    if (bus.out_parity !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_parity: got %b want 0", bus.out_parity);
    end
`endif
    reset_n = 1'b1;
    @(negedge clk);
  endtask

`ifndef STREAM_SPLITTER_PARITY_EN
  task automatic test_single(input logic msb);
    logic [7:0] exp_b [4];
    if (msb) begin
      exp_b[0] = 8'h01; exp_b[1] = 8'h03; exp_b[2] = 8'h07; exp_b[3] = 8'hF0;
    end else begin
      exp_b[0] = 8'hF0; exp_b[1] = 8'h07; exp_b[2] = 8'h03; exp_b[3] = 8'h01;
    end
    drive(1'b1, 32'h0103_07F0, msb, 1'b1);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept msb=%b: in_ready=%b want 1", msb, bus.in_ready);
    end
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_b[k] ||
          bus.out_idx !== IDX_W'(k) || bus.out_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL single msb=%b chunk%0d: valid=%b data=%h idx=%0d last=%b want 1 %h %0d %b",
                 msb, k, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last,
                 exp_b[k], k, (k == 3));
      end
      advance();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle msb=%b: valid=%b data=%h in_ready=%b want 0 00 1",
               msb, bus.out_valid, bus.out_data, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [8];
    exp_b[0] = 8'hF0; exp_b[1] = 8'h07; exp_b[2] = 8'h03; exp_b[3] = 8'h01;
    exp_b[4] = 8'h04; exp_b[5] = 8'h03; exp_b[6] = 8'h02; exp_b[7] = 8'h01;
    drive(1'b1, 32'h0103_07F0, 1'b0, 1'b1);
    advance();
    for (int c = 0; c < 8; c++) begin
      drive(c <= 3, 32'h0102_0304, 1'b0, 1'b1);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_b[c] ||
          bus.out_idx !== IDX_W'(c % 4) || bus.in_ready !== ((c % 4) == 3)) begin
        n_fail++;
        $display("FAIL b2b cycle%0d: valid=%b data=%h idx=%0d in_ready=%b want 1 %h %0d %b",
                 c, bus.out_valid, bus.out_data, bus.out_idx, bus.in_ready,
                 exp_b[c], c % 4, ((c % 4) == 3));
      end
      advance();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic       rdy   [7];
    logic [7:0] exp_b [7];
    int         exp_i [7];
    rdy[0] = 1; exp_b[0] = 8'hF0; exp_i[0] = 0;
    rdy[1] = 1; exp_b[1] = 8'h07; exp_i[1] = 1;
    rdy[2] = 0; exp_b[2] = 8'h03; exp_i[2] = 2;
    rdy[3] = 0; exp_b[3] = 8'h03; exp_i[3] = 2;
    rdy[4] = 0; exp_b[4] = 8'h03; exp_i[4] = 2;
    rdy[5] = 1; exp_b[5] = 8'h03; exp_i[5] = 2;
    rdy[6] = 1; exp_b[6] = 8'h01; exp_i[6] = 3;
    drive(1'b1, 32'h0103_07F0, 1'b0, 1'b1);
    advance();
    for (int c = 0; c < 7; c++) begin
      drive(c < 6, 32'hDEAD_BEEF, 1'b0, rdy[c]);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_b[c] ||
          bus.out_idx !== IDX_W'(exp_i[c]) || bus.in_ready !== (c == 6)) begin
        n_fail++;
        $display("FAIL backpressure cycle%0d: valid=%b data=%h idx=%0d in_ready=%b want 1 %h %0d %b",
                 c, bus.out_valid, bus.out_data, bus.out_idx, bus.in_ready,
                 exp_b[c], exp_i[c], (c == 6));
      end
      advance();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_drain: valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
    drive(1'b1, 32'h0102_0304, 1'b0, 1'b1);
    advance();
    drive(1'b0, '0, 1'b0, 1'b1);
    advance();
    drive(1'b0, '0, 1'b0, 1'b1);
    advance();
    drive(1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    q.delete();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_idx !== '0 ||
        bus.out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_word: valid=%b data=%h idx=%0d last=%b want all 0",
               bus.out_valid, bus.out_data, bus.out_idx, bus.out_last);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_idle: valid=%b in_ready=%b want 0 1",
               bus.out_valid, bus.in_ready);
    end
    drive(1'b1, 32'hAABB_CCDD, 1'b1, 1'b1);
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_b[k] || bus.out_idx !== IDX_W'(k)) begin
        n_fail++;
        $display("FAIL after_reset chunk%0d: valid=%b data=%h idx=%0d want 1 %h %0d",
                 k, bus.out_valid, bus.out_data, bus.out_idx, exp_b[k], k);
      end
      advance();
    end
  endtask
`else
  task automatic test_parity();
    logic [3:0] exp_b [4];
    logic       exp_p [4];
    exp_b[0] = 4'h7; exp_p[0] = 1'b1;
    exp_b[1] = 4'h3; exp_p[1] = 1'b0;
    exp_b[2] = 4'hF; exp_p[2] = 1'b0;
    exp_b[3] = 4'h1; exp_p[3] = 1'b1;
    drive(1'b1, 16'h1F37, 1'b0, 1'b1);
    advance();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_b[k] ||
          bus.out_idx !== IDX_W'(k) || bus.out_parity !== exp_p[k]) begin
        n_fail++;
        $display("FAIL parity chunk%0d: valid=%b data=%h idx=%0d par=%b want 1 %h %0d %b",
                 k, bus.out_valid, bus.out_data, bus.out_idx, bus.out_parity,
                 exp_b[k], k, exp_p[k]);
      end
      advance();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_parity !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_idle: valid=%b par=%b want 0 0", bus.out_valid, bus.out_parity);
    end
  endtask
`endif

  // Random producer (holds a word until taken) and random consumer stalls.
  task automatic test_random();
    logic            cur_v;
    logic [W_IN-1:0] cur_d;
    logic            cur_m;
    bit              acc;
    cur_v = 1'b0;
    cur_d = '0;
    cur_m = 1'b0;
    for (int c = 0; c < 600; c++) begin
      drive(cur_v, cur_d, cur_m, ($urandom_range(0, 3) != 0));
      n_checks++;
      if (bus.in_ready !== exp_in_ready()) begin
        n_fail++;
        $display("FAIL random_in_ready cycle%0d: got %b want %b", c, bus.in_ready, exp_in_ready());
      end
      n_checks++;
      if (q.size() > 0) begin
        if (bus.out_valid !== 1'b1 || bus.out_data !== q[0].data ||
            bus.out_idx !== IDX_W'(q[0].idx) || bus.out_last !== (q[0].idx == N - 1)) begin
          n_fail++;
          $display("FAIL random_out cycle%0d: valid=%b data=%h idx=%0d last=%b want 1 %h %0d %b",
                   c, bus.out_valid, bus.out_data, bus.out_idx, bus.out_last,
                   q[0].data, q[0].idx, (q[0].idx == N - 1));
        end
      end else begin
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_last !== 1'b0) begin
          n_fail++;
          $display("FAIL random_idle cycle%0d: valid=%b data=%h last=%b want 0 0 0",
                   c, bus.out_valid, bus.out_data, bus.out_last);
        end
      end
`ifdef STREAM_SPLITTER_PARITY_EN
      n_checks++;
      if (bus.out_parity !== ((q.size() > 0) ? ^q[0].data : 1'b0)) begin
        n_fail++;
        $display("FAIL random_parity cycle%0d: got %b", c, bus.out_parity);
      end
`endif
      acc = cur_v && exp_in_ready();
      advance();
      if (acc || !cur_v) begin
        cur_v = ($urandom_range(0, 4) != 0);
        cur_d = W_IN'({$urandom, $urandom});
        cur_m = $urandom_range(0, 1) != 0;
      end
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_msb_first = 1'b0;
    bus.out_ready    = 1'b0;
    @(negedge clk);
    test_reset();
`ifndef STREAM_SPLITTER_PARITY_EN
    test_single(1'b0);
    test_single(1'b1);
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
`else
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
